// File: rtl/mag_comparator_serial.sv
// Serial magnitude comparator: walks A and B from the most significant digit,
// DIGIT_W bits per cycle, and stops at the first digit that differs.
module mag_comparator_serial #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIGIT_W = 1,
  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT_W,
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [IDX_W-1:0] diff_idx
);

  // Flipping the sign bit of both operands maps two's complement onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {S_IDLE, S_COMPARE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic [IDX_W-1:0]   diff_idx_q, diff_idx_d;
  logic [DIGIT_W-1:0] a_dig, b_dig;

  assign a_dig = DIGIT_W'(a_q >> (32'(idx_q) * DIGIT_W));
  assign b_dig = DIGIT_W'(b_q >> (32'(idx_q) * DIGIT_W));

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    gt_d       = gt_q;
    eq_d       = eq_q;
    lt_d       = lt_q;
    diff_idx_d = diff_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a ^ (signed_mode ? MSB_MASK : '0);
          b_d     = b ^ (signed_mode ? MSB_MASK : '0);
          idx_d   = IDX_W'(NUM_DIGITS - 1);
          busy_d  = 1'b1;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (a_dig != b_dig || idx_q == '0) begin
          gt_d       = (a_dig > b_dig);
          lt_d       = (a_dig < b_dig);
          eq_d       = (a_dig == b_dig);
          diff_idx_d = idx_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      diff_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
      diff_idx_q <= diff_idx_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign gt       = gt_q;
  assign eq       = eq_q;
  assign lt       = lt_q;
  assign diff_idx = diff_idx_q;

endmodule

// File: tb/tb_mag_comparator_serial.sv
// Bench for mag_comparator_serial: five geometries side by side, directed table,
// hand-written handshake/reset sequences and a randomized run against a numeric model.
module tb_mag_comparator_serial;

  localparam int NCFG = 5;
  int cfg_w [NCFG] = '{8, 8, 8, 16, 4};
  int cfg_d [NCFG] = '{1, 4, 2, 4, 4};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCFG-1:0] start;
  logic            sm;
  logic [15:0]     a_s, b_s;
  logic [NCFG-1:0] busy, done, gt, eq, lt;
  logic [3:0]      didx [NCFG];
  logic [2:0]      di0;
  logic [0:0]      di1;
  logic [1:0]      di2;
  logic [1:0]      di3;
  logic [0:0]      di4;

  assign didx[0] = 4'(di0);
  assign didx[1] = 4'(di1);
  assign didx[2] = 4'(di2);
  assign didx[3] = 4'(di3);
  assign didx[4] = 4'(di4);

  always #5 clk = ~clk;

  mag_comparator_serial #(.WIDTH(8), .DIGIT_W(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .signed_mode(sm), .a(a_s[7:0]), .b(b_s[7:0]),
    .busy(busy[0]), .done(done[0]), .gt(gt[0]), .eq(eq[0]), .lt(lt[0]), .diff_idx(di0));
  mag_comparator_serial #(.WIDTH(8), .DIGIT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .signed_mode(sm), .a(a_s[7:0]), .b(b_s[7:0]),
    .busy(busy[1]), .done(done[1]), .gt(gt[1]), .eq(eq[1]), .lt(lt[1]), .diff_idx(di1));
  mag_comparator_serial #(.WIDTH(8), .DIGIT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .signed_mode(sm), .a(a_s[7:0]), .b(b_s[7:0]),
    .busy(busy[2]), .done(done[2]), .gt(gt[2]), .eq(eq[2]), .lt(lt[2]), .diff_idx(di2));
  mag_comparator_serial #(.WIDTH(16), .DIGIT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .signed_mode(sm), .a(a_s), .b(b_s),
    .busy(busy[3]), .done(done[3]), .gt(gt[3]), .eq(eq[3]), .lt(lt[3]), .diff_idx(di3));
  mag_comparator_serial #(.WIDTH(4), .DIGIT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start[4]), .signed_mode(sm), .a(a_s[3:0]), .b(b_s[3:0]),
    .busy(busy[4]), .done(done[4]), .gt(gt[4]), .eq(eq[4]), .lt(lt[4]), .diff_idx(di4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Numeric reference: order from plain integer compare, index from the top differing digit.
  task automatic ref_model(input int k, input logic [15:0] a, input logic [15:0] b, input logic m,
                           output int g, output int e, output int l, output int idx, output int lat);
    int w, d, nd, av, bv, mask, dmask;
    bit found;
    w = cfg_w[k]; d = cfg_d[k]; nd = w / d;
    mask  = (1 << w) - 1;
    dmask = (1 << d) - 1;
    av = int'(a) & mask;
    bv = int'(b) & mask;
    idx = 0; found = 1'b0;
    for (int i = nd - 1; i >= 0; i--)
      if (!found && (((av >> (i * d)) & dmask) != ((bv >> (i * d)) & dmask))) begin
        idx = i; found = 1'b1;
      end
    lat = found ? nd - idx : nd;
    if (m) begin
      if (av >= (1 << (w - 1))) av = av - (1 << w);
      if (bv >= (1 << (w - 1))) bv = bv - (1 << w);
    end
    g = int'(av > bv); e = int'(av == bv); l = int'(av < bv);
  endtask

  // Issue one comparison on instance k and wait (bounded) for done.
  task automatic run_cmp(input int k, input logic [15:0] a, input logic [15:0] b, input logic m,
                         input bit disturb, output int lat, output bit ok);
    bit glitch;
    @(negedge clk);
    a_s = a; b_s = b; sm = m; start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk("busy_after_start", int'(busy[k]), 1);
    chk("flags_clear_while_busy", int'({gt[k], eq[k], lt[k]}), 0);
    lat = 0; ok = 1'b0; glitch = 1'b0;
    for (int c = 1; c <= 40 && !ok; c++) begin
      @(posedge clk); #1;
      start[k] = 1'b0;
      if (done[k]) begin
        ok = 1'b1; lat = c;
      end else if (disturb) begin
        a_s = 16'($urandom); b_s = 16'($urandom); sm = ~sm;
        if (!glitch && $urandom_range(0, 1) == 1) begin
          start[k] = 1'b1; glitch = 1'b1;
        end
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
    chk("busy_low_with_done", int'(busy[k]), 0);
  endtask

  typedef struct {
    int          k;
    logic [15:0] a, b;
    logic        m;
    int          g, e, l, idx, lat;
  } vec_t;

  vec_t tbl [9];
  int   g, e, l, idx, lat, rg, re, rl, ridx, rlat, cnt;
  bit   ok;
  logic [15:0] ra, rb;
  logic        rm;

  initial begin
    tbl[0] = '{0, 16'h0080, 16'h007F, 1'b0, 1, 0, 0, 7, 1};
    tbl[1] = '{0, 16'h0080, 16'h007F, 1'b1, 0, 0, 1, 7, 1};
    tbl[2] = '{0, 16'h005A, 16'h005A, 1'b0, 0, 1, 0, 0, 8};
    tbl[3] = '{1, 16'h003C, 16'h003A, 1'b0, 1, 0, 0, 0, 2};
    tbl[4] = '{1, 16'h00A0, 16'h0030, 1'b1, 0, 0, 1, 1, 1};
    tbl[5] = '{4, 16'h0009, 16'h0003, 1'b1, 0, 0, 1, 0, 1};
    tbl[6] = '{4, 16'h0009, 16'h0003, 1'b0, 1, 0, 0, 0, 1};
    tbl[7] = '{3, 16'h1234, 16'h1244, 1'b0, 0, 0, 1, 1, 3};
    tbl[8] = '{2, 16'h00C1, 16'h00C1, 1'b1, 0, 1, 0, 0, 4};

    start = '0; sm = 1'b0; a_s = '0; b_s = '0;
    rst_n = 1'b0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_flags", int'(gt | eq | lt), 0);
    for (int k = 0; k < NCFG; k++) chk("reset_diff_idx", int'(didx[k]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    foreach (tbl[i]) begin
      run_cmp(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].m, 1'b0, lat, ok);
      chk($sformatf("tbl%0d_gt", i), int'(gt[tbl[i].k]), tbl[i].g);
      chk($sformatf("tbl%0d_eq", i), int'(eq[tbl[i].k]), tbl[i].e);
      chk($sformatf("tbl%0d_lt", i), int'(lt[tbl[i].k]), tbl[i].l);
      chk($sformatf("tbl%0d_idx", i), int'(didx[tbl[i].k]), tbl[i].idx);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done_single", i), int'(done[tbl[i].k]), 0);
      chk($sformatf("tbl%0d_hold_lt", i), int'(lt[tbl[i].k]), tbl[i].l);
    end

    // Back-to-back: new start raised in the done cycle must be taken with no bubble.
    run_cmp(0, 16'h005A, 16'h005A, 1'b0, 1'b0, lat, ok);
    chk("b2b_first_eq", int'(eq[0]), 1);
    a_s = 16'h0003; b_s = 16'h0005; sm = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("b2b_accepted_busy", int'(busy[0]), 1);
    cnt = 0;
    for (int c = 1; c <= 20 && cnt == 0; c++) begin
      @(posedge clk); #1;
      if (done[0]) cnt = c;
    end
    chk("b2b_lat", cnt, 6);
    chk("b2b_lt", int'(lt[0]), 1);
    chk("b2b_idx", int'(didx[0]), 2);

    // Start ignored while busy, then reset aborts with no done pulse.
    @(negedge clk);
    a_s = 16'h0010; b_s = 16'h0020; sm = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    a_s = 16'h00FF; b_s = 16'h0000; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    chk("ignored_start_busy", int'(busy[0]), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_flags", int'({gt[0], eq[0], lt[0]}), 0);
    chk("abort_idx", int'(didx[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done[0] || busy[0]) cnt++;
    end
    chk("no_done_after_abort", cnt, 0);
    run_cmp(0, 16'h0010, 16'h0020, 1'b0, 1'b0, lat, ok);
    chk("fresh_lt", int'(lt[0]), 1);
    chk("fresh_idx", int'(didx[0]), 5);
    chk("fresh_lat", lat, 3);

    // Randomized regression with operand churn and stray starts while busy.
    for (int k = 0; k < NCFG; k++) begin
      for (int n = 0; n < 400; n++) begin
        ra = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = ra ^ 16'(1 << $urandom_range(0, cfg_w[k] - 1));
          default: rb = 16'($urandom);
        endcase
        rm = 1'($urandom);
        ref_model(k, ra, rb, rm, rg, re, rl, ridx, rlat);
        run_cmp(k, ra, rb, rm, 1'b1, lat, ok);
        g = int'(gt[k]); e = int'(eq[k]); l = int'(lt[k]);
        chk($sformatf("rnd_k%0d_gt a=%h b=%h m=%0d", k, ra, rb, rm), g, rg);
        chk($sformatf("rnd_k%0d_eq a=%h b=%h m=%0d", k, ra, rb, rm), e, re);
        chk($sformatf("rnd_k%0d_lt a=%h b=%h m=%0d", k, ra, rb, rm), l, rl);
        chk($sformatf("rnd_k%0d_onehot", k), g + e + l, 1);
        chk($sformatf("rnd_k%0d_idx a=%h b=%h", k, ra, rb), int'(didx[k]), ridx);
        chk($sformatf("rnd_k%0d_lat a=%h b=%h", k, ra, rb), lat, rlat);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
